// File: rtl/cla_pkg.sv
// Shared definitions for the time-multiplexed wide adder.
// Provides the slice width, the sequencer state encoding and a
// ceiling-log2 helper used to size the byte index counter.
package cla_pkg;

  localparam int unsigned SLICE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ceiling log2 with a floor of 1 so a single-slice build still gets a
  // one-bit index register.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/carrylookahead_adder_8bit.sv
// 8-bit carry-lookahead adder, purely combinational.
// Two 4-bit groups; the group carries come from group generate/propagate
// terms, the in-group carries are expanded from each group's carry-in.
// Ports:
//   a, b  : 8-bit operands
//   cin   : carry-in
//   sum   : 8-bit sum
//   cout  : carry-out of bit 7
module carrylookahead_adder_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [7:0] w_g;
  logic [7:0] w_p;
  logic [1:0] w_gg;
  logic [1:0] w_gp;
  logic [8:0] w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  always_comb begin
    w_gg = '0;
    w_gp = '0;
    for (int unsigned k = 0; k < 2; k++) begin
      w_gg[k] = w_g[4*k];
      w_gp[k] = w_p[4*k];
      for (int unsigned j = 1; j < 4; j++) begin
        w_gg[k] = w_g[4*k+j] | (w_p[4*k+j] & w_gg[k]);
        w_gp[k] = w_gp[k] & w_p[4*k+j];
      end
    end
  end

  always_comb begin
    w_c    = '0;
    w_c[0] = cin;
    w_c[4] = w_gg[0] | (w_gp[0] & cin);
    w_c[8] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & cin);
    for (int unsigned i = 0; i < 8; i++) begin
      if ((i % 4) != 3) w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
    end
  end

  assign sum  = w_p ^ w_c[7:0];
  assign cout = w_c[8];

endmodule

// File: rtl/cla_seq_wide_adder.sv
// Wide (NBYTES x 8-bit) adder built by reusing one 8-bit CLA, one byte per
// clock, LSB byte first, with the carry registered between bytes.
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   start          : request, accepted when busy=0 (IDLE or DONE)
//   a, b, cin      : operands, latched on the accept edge
//   busy           : high in RUN
//   done           : one-cycle pulse when sum/cout/overflow are valid
//   sum            : W-bit result, held until overwritten by the next run
//   cout, overflow : carry-out and signed overflow, held until next done
module cla_seq_wide_adder
  import cla_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [SLICE_W*NBYTES-1:0] a,
  input  logic [SLICE_W*NBYTES-1:0] b,
  input  logic                      cin,
  output logic                      busy,
  output logic                      done,
  output logic [SLICE_W*NBYTES-1:0] sum,
  output logic                      cout,
  output logic                      overflow
);

  localparam int unsigned W    = SLICE_W * NBYTES;
  localparam int unsigned IDXW = clog2(NBYTES);

  state_t            r_state;
  state_t            w_next;
  logic [IDXW-1:0]   r_idx;
  logic [W-1:0]      r_a;
  logic [W-1:0]      r_b;
  logic              r_carry;
  logic [W-1:0]      r_sum;
  logic              r_cout;
  logic              r_ovf;

  logic [SLICE_W-1:0] w_a_byte;
  logic [SLICE_W-1:0] w_b_byte;
  logic [SLICE_W-1:0] w_s_byte;
  logic               w_co;
  logic               w_last;

  assign w_a_byte = r_a[SLICE_W*r_idx +: SLICE_W];
  assign w_b_byte = r_b[SLICE_W*r_idx +: SLICE_W];
  assign w_last   = (r_idx == IDXW'(NBYTES-1));

  carrylookahead_adder_8bit u_cla (
    .a    (w_a_byte),
    .b    (w_b_byte),
    .cin  (r_carry),
    .sum  (w_s_byte),
    .cout (w_co)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE: if (start) w_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (w_last) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = start ? RUN : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
          end
        end
        RUN: begin
          r_sum[SLICE_W*r_idx +: SLICE_W] <= w_s_byte;
          r_carry                         <= w_co;
          if (w_last) begin
            // The MSB byte is being written this cycle, so its sign bit is
            // taken straight from the CLA rather than from r_sum.
            r_cout <= w_co;
            r_ovf  <= (r_a[W-1] == r_b[W-1]) && (w_s_byte[SLICE_W-1] != r_a[W-1]);
          end else begin
            r_idx <= r_idx + IDXW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum      = r_sum;
  assign cout     = r_cout;
  assign overflow = r_ovf;

endmodule

// File: doc/cla_seq_wide_adder.md
Name: cla_seq_wide_adder

Overview:
Sequencer that performs wide (NBYTES×8-bit) additions by time-multiplexing one existing 8-bit carry-lookahead adder instance.
- Operands are latched on a start handshake.
- One byte is processed per clock, LSB byte first, with the carry registered between bytes.
- The full sum, carry-out and signed overflow are presented with a one-cycle done pulse.
- Sits between register-file/ALU-control logic and the 8-bit CLA datapath, avoiding a full-width adder.

Parameters:
NBYTES, 4, number of 8-bit slices; operand width W = 8*NBYTES; legal range 1..16.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous, active-low reset; sampled on rising edge of clk
start  input  1  request; accepted only when busy=0
a  input  W  operand A, sampled on the accept edge
b  input  W  operand B, sampled on the accept edge
cin  input  1  carry-in to byte 0, sampled on the accept edge
busy  output  1  high while a request is being processed (RUN state)
done  output  1  one-cycle pulse when sum/cout/overflow become valid
sum  output  W  result; held stable from done until the next accept
cout  output  1  carry out of the MSB byte
overflow  output  1  two's-complement overflow of the W-bit add

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State=IDLE; byte index=0.
  - busy=0, done=0, sum=0, cout=0, overflow=0.
  - Internal operand and carry registers cleared.
- Reset has priority over all other inputs. Reset mid-RUN abandons the operation; no done is produced.
- FSM states: IDLE, RUN, DONE.
  - IDLE: busy=0. On start=1, latch a, b, cin → RUN with idx=0.
  - RUN: busy=1. Each cycle:
    - Drive the CLA with a_q[8*idx+:8], b_q[8*idx+:8], carry_q.
    - Write the CLA sum into sum[8*idx+:8]; carry_q <= CLA cout.
    - If idx==NBYTES-1 → DONE; else idx+1.
    - start is ignored in RUN.
  - DONE: done=1 for exactly this cycle, busy=0.
    - cout = final carry_q.
    - overflow = (a_q[W-1]==b_q[W-1]) && (sum[W-1]!=a_q[W-1]).
    - start=1 in DONE is accepted (latch, go to RUN), giving back-to-back throughput.
    - Otherwise → IDLE.
- Latency: accept edge at cycle 0; byte k is written at the end of cycle k+1. done is high during cycle NBYTES+1. Throughput is one operation per NBYTES+1 cycles.
- sum is updated byte-wise during RUN; it is valid only when done=1 and in IDLE afterwards. It keeps its value until the next operation overwrites bytes.
- cout and overflow are registered at the RUN→DONE transition and held until the next DONE.
- Operand inputs may change freely after the accept edge; only the latched copies are used.
- Index counter width is clog2(NBYTES) (minimum 1). NBYTES=1 gives a single RUN cycle.
- No wrap-around of idx beyond NBYTES-1; the counter resets to 0 on each accept.

Decomposition:
- Shared package cla_pkg:
  - SLICE_W=8.
  - FSM state enum {IDLE, RUN, DONE}, 2-bit encoding.
  - clog2 helper function.
- Sub-module: one instance of the existing carrylookahead_adder_8bit (ports a, b, cin, sum, cout), used combinationally inside this block.
- No other sub-modules.

Test Plan:
1. NBYTES=4: a=32'h0000_00AF, b=32'h0000_0035, cin=1 → done at cycle 5 after accept; sum=32'h0000_00E5, cout=0, overflow=0; busy high for exactly 4 cycles.
2. Carry ripple across slices: a=32'h00FF_FFFF, b=32'h0000_0001, cin=0 → sum=32'h0100_0000, cout=0. Then a=32'hFFFF_FFFF, b=32'h0000_0001 → sum=0, cout=1, overflow=0.
3. Signed overflow: a=32'h7FFF_FFFF, b=32'h0000_0001, cin=0 → sum=32'h8000_0000, cout=0, overflow=1. Then a=32'hEB00_0000, b=32'hB500_0000 → sum=32'hA000_0000, cout=1, overflow=0.
4. Handshake:
   - Pulse start in RUN with different operands → ignored; result of the first operation unchanged.
   - Assert start in the DONE cycle → new operation accepted; its done occurs NBYTES+1 cycles later.
5. Reset mid-operation: rst_n=0 at RUN idx=2 for one cycle → next cycle busy=0, done=0, sum=0, cout=0, overflow=0. No done pulse follows. A subsequent start works normally.
6. Exhaustive NBYTES=1 build: all 2^17 combinations of (a, b, cin) checked against the reference model {cout,sum}=a+b+cin and the overflow formula. done occurs exactly 2 cycles after each accept.
